uart_rx_frame_parser: RTL and testbench

//  Downstream consumer of the UART receive path: pops bytes from the RX FIFO
//  (R_data/rd_uart/rx_empty) and parses framed packets SOF|LEN|PAYLOAD[LEN]|CSUM.

---
 rtl/uart_rx_frame_parser.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_parser
//
// Pops bytes from a first-word-fall-through UART RX FIFO and parses framed
// packets of the form SOF | LEN | PAYLOAD[LEN] | CSUM. The checksum is the
// modulo-2^DATA_WIDTH sum of LEN and all payload bytes. Payload bytes are
// streamed to the host through a one-entry valid/ready output register before
// the checksum is known. Each frame ends with a one-cycle frame_ok or
// frame_err pulse. err_code keeps the cause until the next pulse.
//
// Ports
//   UCLK       in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   R_data     in   RX FIFO head byte, valid while rx_empty = 0
//   rx_empty   in   RX FIFO empty flag
//   rd_uart    out  pop strobe; the head byte is consumed this cycle
//   pay_data   out  payload byte to the host
//   pay_valid  out  pay_data valid, held until pay_ready
//   pay_ready  in   host accepts pay_data when pay_valid & pay_ready
//   frame_ok   out  one-cycle pulse: frame complete, checksum good
//   frame_err  out  one-cycle pulse: frame aborted or checksum bad
//   err_code   out  00 none, 01 bad LEN, 10 bad CSUM, 11 timeout
// -----------------------------------------------------------------------------
module uart_rx_frame_parser #(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = 8'hA5,
  parameter int                    MAX_LEN        = 16,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] R_data,
  input  logic                  rx_empty,
  output logic                  rd_uart,
  output logic [DATA_WIDTH-1:0] pay_data,
  output logic                  pay_valid,
  input  logic                  pay_ready,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam int                    CNT_W     = $clog2(MAX_LEN + 1);
  localparam int                    TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   pay_data_q, pay_data_d;
  logic                    pay_valid_q, pay_valid_d;
  logic                    frame_ok_q, frame_ok_d;
  logic                    frame_err_q, frame_err_d;
  err_e                    err_code_q, err_code_d;

  logic accept;
  logic pop;
  logic stall;
  logic tmr_run;
  logic timeout;
  logic len_ok;
  logic is_sof;

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of the order in which processes run.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      csum_q      <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / control decode (combinational from state and pay_valid)
  // ---------------------------------------------------------------------------
  always_comb begin
    // In PAYLOAD the one-entry output register must be free or draining.
    accept  = (state_q == S_PAYLOAD) ? (~pay_valid_q | pay_ready) : 1'b1;
    pop     = ~rx_empty & accept;
    // The host holding off with a byte already waiting does not count as
    // inactivity on the line, so the timer freezes.
    stall   = (state_q == S_PAYLOAD) & pay_valid_q & ~pay_ready & ~rx_empty;
    tmr_run = (state_q != S_IDLE) & ~stall;
    timeout = tmr_run & ~pop & (timer_q == TMR_LAST);
    len_ok  = (R_data != '0) && (R_data <= MAX_LEN_B);
    is_sof  = (R_data == SOF_BYTE);
  end

  assign rd_uart   = pop;
  assign pay_data  = pay_data_q;
  assign pay_valid = pay_valid_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (pop) begin
      unique case (state_q)
        S_IDLE:    if (is_sof) state_d = S_LEN;
        S_LEN:     state_d = len_ok ? S_PAYLOAD : S_IDLE;
        S_PAYLOAD: if (count_q == CNT_W'(1)) state_d = S_CSUM;
        S_CSUM:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    csum_d      = csum_q;
    count_d     = count_q;
    timer_d     = timer_q;
    pay_data_d  = pay_data_q;
    pay_valid_d = pay_valid_q & ~pay_ready;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if ((state_q == S_IDLE) || pop || timeout) begin
      timer_d = '0;
    end else if (tmr_run) begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (timeout) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end

    if (pop) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_sof) csum_d = '0;
        end
        S_LEN: begin
          if (len_ok) begin
            count_d = CNT_W'(R_data);
            csum_d  = R_data;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
        S_PAYLOAD: begin
          // A load in the same cycle as a handshake keeps pay_valid set.
          pay_data_d  = R_data;
          pay_valid_d = 1'b1;
          csum_d      = csum_q + R_data;
          count_d     = count_q - CNT_W'(1);
        end
        S_CSUM: begin
          if (R_data == csum_q) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_parser
//
// Drives uart_rx_frame_parser from a queue-based FWFT FIFO model. Expected
// payload bytes and frame results are pushed to scoreboard queues when a
// frame is queued, and a monitor pops and compares them as the DUT emits
// handshakes and pulses. The checksum is computed by the bench as the
// 8-bit sum of LEN and the payload bytes.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_parser;

  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic       ok;
    logic [1:0] code;
  } ev_t;

  logic       UCLK;
  logic       reset;
  logic [7:0] R_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  logic [7:0] fifo[$];
  logic [7:0] exp_pay[$];
  ev_t        exp_ev[$];
  logic [7:0] csum_m;
  int         rd_count;
  int         ev_seen;
  int         n_checks;
  int         n_errors;

  uart_rx_frame_parser #(
    .DATA_WIDTH    (8),
    .SOF_BYTE      (8'hA5),
    .MAX_LEN       (16),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .UCLK     (UCLK),
    .reset    (reset),
    .R_data   (R_data),
    .rx_empty (rx_empty),
    .rd_uart  (rd_uart),
    .pay_data (pay_data),
    .pay_valid(pay_valid),
    .pay_ready(pay_ready),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  initial UCLK = 1'b0;
  always #5 UCLK = ~UCLK;

  // FWFT FIFO model: a pop seen at the negedge is consumed at the next edge.
  initial begin : fifo_model
    logic pop_now;
    rx_empty = 1'b1;
    R_data   = 8'h00;
    forever begin
      @(negedge UCLK);
      pop_now = rd_uart;
      @(posedge UCLK);
      #2;
      if (pop_now && fifo.size() > 0) begin
        void'(fifo.pop_front());
        rd_count++;
      end
      rx_empty = (fifo.size() == 0);
      R_data   = rx_empty ? 8'h00 : fifo[0];
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge UCLK) begin
    if (reset) begin
      if (pay_valid && pay_ready) begin
        n_checks++;
        if (exp_pay.size() == 0) begin
          n_errors++;
          $display("FAIL payload: unexpected byte %02h, required none", pay_data);
        end else begin
          logic [7:0] e;
          e = exp_pay.pop_front();
          if (pay_data !== e) begin
            n_errors++;
            $display("FAIL payload: got %02h, required %02h", pay_data, e);
          end
        end
      end
      if (frame_ok || frame_err) begin
        ev_seen++;
        n_checks++;
        if (exp_ev.size() == 0) begin
          n_errors++;
          $display("FAIL frame_event: unexpected ok=%0b err=%0b code=%02b, required none",
                   frame_ok, frame_err, err_code);
        end else begin
          ev_t e;
          e = exp_ev.pop_front();
          if ({frame_ok, frame_err, err_code} !== {e.ok, ~e.ok, e.code}) begin
            n_errors++;
            $display("FAIL frame_event: got ok=%0b err=%0b code=%02b, required ok=%0b err=%0b code=%02b",
                     frame_ok, frame_err, err_code, e.ok, ~e.ok, e.code);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge UCLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic start_frame(input logic [7:0] len);
    push(8'hA5);
    push(len);
    csum_m = len;
  endtask

  task automatic pay(input logic [7:0] b);
    push(b);
    exp_pay.push_back(b);
    csum_m = csum_m + b;
  endtask

  task automatic end_good();
    ev_t e;
    push(csum_m);
    e.ok = 1'b1; e.code = 2'b00;
    exp_ev.push_back(e);
  endtask

  task automatic expect_err(input logic [1:0] code);
    ev_t e;
    e.ok = 1'b0; e.code = code;
    exp_ev.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge UCLK);
      if (fifo.size() == 0 && exp_pay.size() == 0 && exp_ev.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s: drain bound expired, fifo=%0d pay=%0d ev=%0d left, required 0/0/0",
               name, fifo.size(), exp_pay.size(), exp_ev.size());
      fifo.delete();
      exp_pay.delete();
      exp_ev.delete();
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    pay_ready = 1'b1;
    fifo.delete();
    exp_pay.delete();
    exp_ev.delete();
    repeat (3) @(posedge UCLK);
    #1 reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b0;
    pay_ready = 1'b1;
    repeat (2) @(posedge UCLK);
    @(negedge UCLK);
    n_checks++;
    if ({rd_uart, pay_data, pay_valid, frame_ok, frame_err, err_code} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rd=%0b data=%02h v=%0b ok=%0b err=%0b code=%02b, required all 0",
               rd_uart, pay_data, pay_valid, frame_ok, frame_err, err_code);
    end
    sync();
    reset = 1'b1;
  endtask

  task automatic test_basic();
    sync();
    rd_count = 0;
    start_frame(8'h03);
    pay(8'h11); pay(8'h22); pay(8'h33);
    end_good();
    wait_drain(100, "basic");
    repeat (2) @(negedge UCLK);
    n_checks++;
    if (rd_count != 6) begin
      n_errors++;
      $display("FAIL basic_pops: got %0d rd_uart pulses, required 6", rd_count);
    end
    n_checks++;
    if (err_code !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_code_held: got %02b, required 00", err_code);
    end
  endtask

  task automatic test_drop_idle();
    sync();
    rd_count = 0;
    push(8'h00); push(8'hFF);
    start_frame(8'h01);
    pay(8'h7E);
    end_good();
    wait_drain(100, "drop_idle");
    repeat (2) @(negedge UCLK);
    n_checks++;
    if (rd_count != 6) begin
      n_errors++;
      $display("FAIL drop_idle_pops: got %0d rd_uart pulses, required 6", rd_count);
    end
  endtask

  task automatic test_bad_len();
    sync();
    push(8'hA5); push(8'h00); expect_err(2'b01);
    push(8'hA5); push(8'h11); expect_err(2'b01);
    push(8'h22);                       // dropped in IDLE
    start_frame(8'h01);
    pay(8'h05);
    end_good();
    wait_drain(100, "bad_len");
  endtask

  task automatic test_max_len();
    sync();
    start_frame(8'd16);
    for (int i = 0; i < 16; i++) begin
      // SOF value inside the payload is plain data.
      pay((i == 5) ? 8'hA5 : 8'(8'h40 + i));
    end
    end_good();
    wait_drain(200, "max_len");
  endtask

  task automatic test_bad_csum();
    sync();
    start_frame(8'h02);
    pay(8'h10); pay(8'h20);
    push(8'h31);                       // correct sum would be 32
    expect_err(2'b10);
    wait_drain(100, "bad_csum");
    repeat (2) @(negedge UCLK);
    n_checks++;
    if (err_code !== 2'b10) begin
      n_errors++;
      $display("FAIL bad_csum_code_held: got %02b, required 10", err_code);
    end
  endtask

  task automatic test_backpressure();
    sync();
    pay_ready = 1'b0;
    start_frame(8'h02);
    pay(8'hAA); pay(8'hBB);
    end_good();
    // Hold well past the timeout interval; a waiting byte must freeze the timer.
    repeat (TIMEOUT + 40) @(negedge UCLK);
    n_checks++;
    if ({pay_valid, pay_data, rd_uart} !== {1'b1, 8'hAA, 1'b0}) begin
      n_errors++;
      $display("FAIL backpressure_hold: got v=%0b data=%02h rd=%0b, required v=1 data=AA rd=0",
               pay_valid, pay_data, rd_uart);
    end
    n_checks++;
    if (fifo.size() != 2) begin
      n_errors++;
      $display("FAIL backpressure_fifo: got %0d bytes waiting, required 2", fifo.size());
    end
    sync();
    pay_ready = 1'b1;
    wait_drain(100, "backpressure");
  endtask

  task automatic test_back_to_back();
    sync();
    start_frame(8'h02);
    pay(8'h01); pay(8'h02);
    end_good();
    start_frame(8'h03);
    pay(8'hC0); pay(8'hC1); pay(8'hC2);
    end_good();
    wait_drain(100, "back_to_back");
  endtask

  task automatic test_timeout();
    sync();
    start_frame(8'h04);
    pay(8'h01);
    expect_err(2'b11);
    wait_drain(TIMEOUT + 60, "timeout");
    repeat (3) @(negedge UCLK);
    n_checks++;
    if (err_code !== 2'b11) begin
      n_errors++;
      $display("FAIL timeout_code_held: got %02b, required 11", err_code);
    end
  endtask

  task automatic test_reset_midframe();
    int seen0;
    sync();
    start_frame(8'h04);
    pay(8'h01); pay(8'h02);
    wait_drain(50, "midframe_prefill");
    sync();
    seen0 = ev_seen;
    reset = 1'b0;
    fifo.delete();
    @(negedge UCLK);
    n_checks++;
    if ({rd_uart, pay_data, pay_valid, frame_ok, frame_err, err_code} !== 14'd0) begin
      n_errors++;
      $display("FAIL midframe_reset_outputs: got rd=%0b data=%02h v=%0b ok=%0b err=%0b code=%02b, required all 0",
               rd_uart, pay_data, pay_valid, frame_ok, frame_err, err_code);
    end
    sync();
    reset = 1'b1;
    repeat (TIMEOUT + 40) @(negedge UCLK);
    n_checks++;
    if (ev_seen != seen0) begin
      n_errors++;
      $display("FAIL midframe_no_pulse: got %0d pulses after reset, required 0", ev_seen - seen0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rd_count  = 0;
    ev_seen   = 0;
    csum_m    = 8'h00;
    reset     = 1'b0;
    pay_ready = 1'b1;

    test_reset();
    test_basic();
    test_drop_idle();
    test_bad_len();
    test_max_len();
    test_bad_csum();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    apply_reset();
    test_reset_midframe();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
